// File: rtl/lcd_refresh_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_refresh_ctrl_if
// Brief    : Character-buffer read port, refresh handshake and LCD pin bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface lcd_refresh_ctrl_if;
  logic       start;
  logic [4:0] char_addr;
  logic [7:0] char_data;
  logic       busy;
  logic       done;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;

  modport master (
    input  start, char_data,
    output char_addr, busy, done, lcd_rs, lcd_rw, lcd_en, lcd_data
  );

  modport slave (
    output start, char_data,
    input  char_addr, busy, done, lcd_rs, lcd_rw, lcd_en, lcd_data
  );
endinterface
`default_nettype wire

// File: rtl/lcd_refresh_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lcd_refresh_ctrl
// Brief    : HD44780 16x2 power-up/init sequencer and full-screen refresher.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_refresh_ctrl #(
  parameter int POWERUP_CYC    = 2_000_000,
  parameter int E_PULSE_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2_500,
  parameter int CLEAR_WAIT_CYC = 100_000
) (
  input  wire logic          clk,
  input  wire logic          rst,
  lcd_refresh_ctrl_if.master bus
);
  localparam int c_max_ab  = (POWERUP_CYC > E_PULSE_CYC) ? POWERUP_CYC : E_PULSE_CYC;
  localparam int c_max_cd  = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC : CLEAR_WAIT_CYC;
  localparam int c_cnt_max = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
  localparam int c_cw      = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

  localparam logic [c_cw-1:0] c_pwr_tc = c_cw'(POWERUP_CYC - 1);
  localparam logic [c_cw-1:0] c_pls_tc = c_cw'(E_PULSE_CYC - 1);
  localparam logic [c_cw-1:0] c_cmd_tc = c_cw'(CMD_WAIT_CYC - 1);
  localparam logic [c_cw-1:0] c_clr_tc = c_cw'(CLEAR_WAIT_CYC - 1);
  localparam logic [5:0]      c_init_last = 6'd3;
  localparam logic [5:0]      c_ref_last  = 6'd33;
  localparam logic [5:0]      c_clear_idx = 6'd2;

  typedef enum logic [1:0] {S_PWRUP, S_INIT, S_IDLE, S_REFRESH} state_t;
  typedef enum logic [2:0] {P_ADDR, P_LOAD, P_SETUP, P_PULSE, P_WAIT} phase_t;

  state_t          r_state, w_state_nx;
  phase_t          r_phase, w_phase_nx;
  logic [5:0]      r_idx, w_idx_nx;
  logic [c_cw-1:0] r_cnt, w_cnt_nx, w_wait_tc;
  logic            r_pend, w_pend_nx;
  logic [4:0]      r_addr, w_addr_nx;
  logic [7:0]      r_data, w_data_nx;
  logic            r_rs, w_rs_nx;
  logic            r_en, w_en_nx;
  logic            r_busy, w_busy_nx;
  logic            r_done, w_done_nx;
  logic            w_sending, w_sending_nx;

  // Refresh byte index 0 is the line-1 DDRAM address, 17 the line-2 address.
  function automatic logic is_data(input logic refresh, input logic [5:0] idx);
    return refresh && (idx != 6'd0) && (idx != 6'd17);
  endfunction

  function automatic logic [7:0] cmd_byte(input logic refresh, input logic [5:0] idx);
    logic [7:0] b;
    if (refresh) begin
      b = (idx == 6'd0) ? 8'h80 : 8'hC0;
    end else begin
      case (idx)
        6'd0:    b = 8'h38;
        6'd1:    b = 8'h0C;
        6'd2:    b = 8'h01;
        default: b = 8'h06;
      endcase
    end
    return b;
  endfunction

  function automatic logic [4:0] buf_addr(input logic [5:0] idx);
    return (idx <= 6'd16) ? 5'(idx - 6'd1) : 5'(idx - 6'd2);
  endfunction

  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    w_idx_nx   = r_idx;
    w_cnt_nx   = r_cnt;
    w_pend_nx  = r_pend;
    w_wait_tc  = (r_state == S_INIT && r_idx == c_clear_idx) ? c_clr_tc : c_cmd_tc;
    w_sending  = (r_state == S_INIT) || (r_state == S_REFRESH);

    case (r_state)
      S_PWRUP: begin
        if (r_cnt == c_pwr_tc) begin
          w_state_nx = S_INIT;
          w_phase_nx = P_ADDR;
          w_idx_nx   = '0;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_IDLE: begin
        if (bus.start || r_pend) begin
          w_state_nx = S_REFRESH;
          w_phase_nx = P_ADDR;
          w_idx_nx   = '0;
          w_cnt_nx   = '0;
          w_pend_nx  = 1'b0;
        end
      end
      default: begin
        case (r_phase)
          P_ADDR:  w_phase_nx = P_LOAD;
          P_LOAD:  w_phase_nx = P_SETUP;
          P_SETUP: begin
            w_phase_nx = P_PULSE;
            w_cnt_nx   = '0;
          end
          P_PULSE: begin
            if (r_cnt == c_pls_tc) begin
              w_phase_nx = P_WAIT;
              w_cnt_nx   = '0;
            end else begin
              w_cnt_nx = r_cnt + 1'b1;
            end
          end
          default: begin
            if (r_cnt == w_wait_tc) begin
              w_cnt_nx = '0;
              if (r_idx == ((r_state == S_INIT) ? c_init_last : c_ref_last)) begin
                w_state_nx = S_IDLE;
              end else begin
                w_idx_nx   = r_idx + 6'd1;
                w_phase_nx = P_ADDR;
              end
            end else begin
              w_cnt_nx = r_cnt + 1'b1;
            end
          end
        endcase
      end
    endcase

    if (bus.start && r_state != S_IDLE) begin
      w_pend_nx = 1'b1;
    end

    // Outputs are registered from next-state so each takes effect on the cycle it names.
    w_sending_nx = (w_state_nx == S_INIT) || (w_state_nx == S_REFRESH);
    w_addr_nx    = r_addr;
    if (w_state_nx == S_REFRESH && w_phase_nx == P_ADDR && is_data(1'b1, w_idx_nx)) begin
      w_addr_nx = buf_addr(w_idx_nx);
    end

    w_data_nx = r_data;
    w_rs_nx   = r_rs;
    if (w_sending && r_phase == P_LOAD) begin
      w_rs_nx   = is_data(r_state == S_REFRESH, r_idx);
      w_data_nx = w_rs_nx ? bus.char_data : cmd_byte(r_state == S_REFRESH, r_idx);
    end

    w_en_nx   = w_sending_nx && (w_phase_nx == P_PULSE);
    w_done_nx = (w_state_nx == S_REFRESH) && (w_phase_nx == P_WAIT) &&
                (w_idx_nx == c_ref_last) && (w_cnt_nx == c_cmd_tc);
    w_busy_nx = (w_state_nx != S_IDLE) || w_pend_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_PWRUP;
      r_phase <= P_ADDR;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_rs    <= 1'b0;
      r_en    <= 1'b0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_phase <= w_phase_nx;
      r_idx   <= w_idx_nx;
      r_cnt   <= w_cnt_nx;
      r_pend  <= w_pend_nx;
      r_addr  <= w_addr_nx;
      r_data  <= w_data_nx;
      r_rs    <= w_rs_nx;
      r_en    <= w_en_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
    end
  end

  assign bus.char_addr = r_addr;
  assign bus.lcd_data  = r_data;
  assign bus.lcd_rs    = r_rs;
  assign bus.lcd_en    = r_en;
  assign bus.lcd_rw    = 1'b0;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule
`default_nettype wire

// File: doc/lcd_refresh_ctrl.md
# lcd_refresh_ctrl

Sequencer for the DE0-Nano 16x2 HD44780-compatible character LCD. After reset it runs the power-up wait and the controller init command sequence. On each `start` it copies a 32-entry character buffer (bytes 0-15 to line 1, bytes 16-31 to line 2) onto the LCD bus with correct E-strobe timing. It sits between the character buffer and the LCD pins, and is the only driver of the LCD bus.

## Interface
- `POWERUP_CYC`, default 2_000_000: idle cycles after reset before the first bus write (40 ms at 50 MHz).
- `E_PULSE_CYC`, default 25: cycles `lcd_en` is held high per byte.
- `CMD_WAIT_CYC`, default 2_500: cycles `lcd_en` is held low after each strobe.
- `CLEAR_WAIT_CYC`, default 100_000: replaces `CMD_WAIT_CYC` after the 0x01 clear command.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a full refresh; sampled every cycle.
- `char_addr` out 5: character buffer read address (0-31).
- `char_data` in 8: buffer read data, valid one cycle after `char_addr` (synchronous-read RAM).
- `busy` out 1: high during init and during a refresh.
- `done` out 1: single-cycle pulse marking the end of a refresh.
- `lcd_rs` out 1: LCD register select (0 = command, 1 = data).
- `lcd_rw` out 1: LCD read/write; tied to 0 (write only).
- `lcd_en` out 1: LCD enable strobe.
- `lcd_data` out 8: LCD data bus.

## Operation
- All outputs are registered.
- Reset values: `lcd_en`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=0x00, `char_addr`=0, `busy`=1, `done`=0, pending flag cleared.
- States: PWRUP → INIT → IDLE ↔ REFRESH. Every byte sent uses the substates ADDR → LOAD → SETUP → PULSE → WAIT.
- PWRUP: counts `POWERUP_CYC` cycles, then enters INIT.
- INIT: sends commands with rs=0 in the order 0x38, 0x0C, 0x01, 0x06. Then enters IDLE and drops `busy`.
- IDLE: `busy`=0. If `start` is high or the pending flag is set, enter REFRESH and clear the pending flag.
- REFRESH sends 34 bytes in this order:
  - 0x80 (rs=0);
  - buffer bytes 0-15 (rs=1);
  - 0xC0 (rs=0);
  - buffer bytes 16-31 (rs=1).
  - `done`=1 during the final WAIT cycle of byte 31. Return to IDLE on the next cycle.
- Byte substates:
  - ADDR, 1 cycle: `char_addr` is driven with the index. For commands, `char_addr` holds its previous value.
  - LOAD, 1 cycle: at the closing edge, `lcd_data` ← `char_data` (data bytes) or the command constant, and `lcd_rs` is set.
  - SETUP, 1 cycle: `lcd_en`=0, bus stable.
  - PULSE: `lcd_en`=1 for `E_PULSE_CYC` cycles.
  - WAIT: `lcd_en`=0 for `CMD_WAIT_CYC` cycles, or `CLEAR_WAIT_CYC` after 0x01.
- `lcd_data` and `lcd_rs` change only at the LOAD edge. They are stable from SETUP through the end of WAIT.
- `start` while `busy` (during PWRUP, INIT or REFRESH) sets the pending flag. Multiple requests collapse into one. A pending request is served immediately after init completes, or immediately after the current refresh (`busy` stays high through the IDLE transition cycle).
- `rst` mid-operation: returns to PWRUP at that edge with reset values (`lcd_en` low at once). The pending flag is lost.
- Counters are sized to max(param) and use a compare-to-terminal-count-minus-one; there is no wrap-around.

## Timing
- Bytes per refresh: 34. Cycles per byte: 3 + `E_PULSE_CYC` + wait.
- Init cycle count after `rst` falls:
  - `POWERUP_CYC` + 4·(3+`E_PULSE_CYC`) + 3·`CMD_WAIT_CYC` + `CLEAR_WAIT_CYC`.
  - `busy` falls on the following cycle.
- Refresh: `start` sampled high in IDLE gives `busy`=1 on the next cycle, which is also the first ADDR cycle.
- Refresh length: `done` pulses 34·(3+`E_PULSE_CYC`+`CMD_WAIT_CYC`) − 1 cycles after that first ADDR cycle. `busy`=0 on the next cycle unless a request is pending.
- `lcd_rw` is 0 in every cycle.

## Test plan
All scenarios use `POWERUP_CYC`=20, `E_PULSE_CYC`=2, `CMD_WAIT_CYC`=3, `CLEAR_WAIT_CYC`=10, giving 8 cycles per normal byte.

- **Init:** release `rst` → four `lcd_en` pulses with `lcd_data` 0x38, 0x0C, 0x01, 0x06 and rs=0. Each pulse is 2 cycles wide. Gap after 0x01 is ≥10 cycles. `busy` falls 59 cycles after reset release.
- **Refresh:** buffer loaded with 0x0A, 0x1A, …, 0x4D; pulse `start` in IDLE → 34 strobes in order 0x80, bytes 0-15 (rs=1), 0xC0, bytes 16-31. `done` pulses once, 271 cycles after the first ADDR cycle.
- **Setup/hold:** on every strobe, `lcd_data` and `lcd_rs` are unchanged from 1 cycle before `lcd_en` rises to 3 cycles after it falls.
- **Start during busy:** assert `start` during INIT and again twice mid-refresh → exactly one refresh after init, then exactly one back-to-back refresh with no `busy` gap. Total `done` pulses: 2.
- **Reset mid-refresh:** assert `rst` while `lcd_en`=1 at byte 10 → `lcd_en`=0 and `busy`=1 on the next cycle. Full init repeats. No `done` pulse occurs and no refresh follows.
